// File: rtl/clock_pkg.sv
// Shared types and limits for the clock auto-set sequencer.
package clock_pkg;

  typedef enum logic [3:0] {
    IDLE     = 4'd0,
    MIN_CHK  = 4'd1,
    MIN_ADV  = 4'd2,
    MIN_WAIT = 4'd3,
    HRS_CHK  = 4'd4,
    HRS_ADV  = 4'd5,
    HRS_WAIT = 4'd6,
    DAY_CHK  = 4'd7,
    DAY_ADV  = 4'd8,
    DAY_WAIT = 4'd9,
    DONE     = 4'd10
  } autoset_state_e;

  localparam logic [6:0] MIN_MAX   = 7'd59;
  localparam logic [6:0] HRS_MAX   = 7'd11;
  localparam logic [2:0] DAY_MAX   = 3'd6;
  localparam logic [6:0] MAX_STEPS = 7'd91;

endpackage

// File: rtl/autoset_pulser.sv
// Registers the one-cycle advance pulse and times the settle gap that follows it.
module autoset_pulser #(
  parameter int SETTLE = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [2:0] adv_req,
  output logic [2:0] adv_pulse,
  output logic       settled
);

  localparam logic [2:0] SETTLE_CNT = 3'(SETTLE);

  logic [2:0] pulse_q, pulse_d;
  logic [2:0] cnt_q, cnt_d;

  // Reload the settle timer on every pulse, then count it down to zero.
  always_comb begin
    pulse_d = adv_req;
    cnt_d   = cnt_q;
    if (adv_req != 3'b000) begin
      cnt_d = SETTLE_CNT;
    end else if (cnt_q != 3'd0) begin
      cnt_d = cnt_q - 3'd1;
    end else begin
      cnt_d = cnt_q;
    end
  end

  // Pulse and timer registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pulse_q <= 3'b000;
      cnt_q   <= 3'd0;
    end else begin
      pulse_q <= pulse_d;
      cnt_q   <= cnt_d;
    end
  end

  assign adv_pulse = pulse_q;
  assign settled   = (cnt_q == 3'd0);

endmodule

// File: rtl/clock_autoset.sv
// Drives the clock-core set buttons until live time matches a latched target.
// Optional AUTOSET_TIMEOUT_EN bounds the number of advance pulses per operation.
module clock_autoset
  import clock_pkg::*;
#(
  parameter int SETTLE = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       abort,
  input  logic [6:0] tgt_min,
  input  logic [6:0] tgt_hrs,
  input  logic       tgt_pm,
  input  logic [2:0] tgt_day,
  input  logic [6:0] cur_min,
  input  logic [6:0] cur_hrs,
  input  logic       cur_pm,
  input  logic [2:0] cur_day,
  output logic       timeset,
  output logic       minadv,
  output logic       hrsadv,
  output logic       dayadv,
  output logic       busy,
  output logic       done,
  output logic       err
);

  autoset_state_e state_q, state_d;
  logic [6:0] tmin_q, tmin_d, thrs_q, thrs_d;
  logic       tpm_q, tpm_d;
  logic [2:0] tday_q, tday_d;
  logic       err_d, err_q, done_q, busy_q, timeset_q;
  logic [2:0] adv_req, adv_pulse;
  logic       settled, step_ok;
  logic       min_match, hrs_match, day_match;

`ifdef AUTOSET_TIMEOUT_EN
  logic [6:0] steps_q, steps_d;
  assign step_ok = (steps_q < MAX_STEPS);
`else
  assign step_ok = 1'b1;
`endif

  assign min_match = (cur_min == tmin_q);
  assign hrs_match = (cur_hrs == thrs_q) && (cur_pm == tpm_q);
  assign day_match = (cur_day == tday_q);

  // Phase sequencing; the day is set last since an hour wrap can move it.
  always_comb begin
    state_d = state_q;
    tmin_d  = tmin_q;
    thrs_d  = thrs_q;
    tpm_d   = tpm_q;
    tday_d  = tday_q;
    err_d   = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          tmin_d = tgt_min;
          thrs_d = tgt_hrs;
          tpm_d  = tgt_pm;
          tday_d = tgt_day;
          if ((tgt_min > MIN_MAX) || (tgt_hrs > HRS_MAX) || (tgt_day > DAY_MAX)) begin
            err_d = 1'b1;
          end else begin
            state_d = MIN_CHK;
          end
        end else begin
          state_d = IDLE;
        end
      end
      MIN_CHK: begin
        if (min_match) begin
          state_d = HRS_CHK;
        end else if (step_ok) begin
          state_d = MIN_ADV;
        end else begin
          err_d   = 1'b1;
          state_d = IDLE;
        end
      end
      MIN_ADV:  state_d = MIN_WAIT;
      MIN_WAIT: state_d = settled ? MIN_CHK : MIN_WAIT;
      HRS_CHK: begin
        if (hrs_match) begin
          state_d = DAY_CHK;
        end else if (step_ok) begin
          state_d = HRS_ADV;
        end else begin
          err_d   = 1'b1;
          state_d = IDLE;
        end
      end
      HRS_ADV:  state_d = HRS_WAIT;
      HRS_WAIT: state_d = settled ? HRS_CHK : HRS_WAIT;
      DAY_CHK: begin
        if (day_match) begin
          state_d = DONE;
        end else if (step_ok) begin
          state_d = DAY_ADV;
        end else begin
          err_d   = 1'b1;
          state_d = IDLE;
        end
      end
      DAY_ADV:  state_d = DAY_WAIT;
      DAY_WAIT: state_d = settled ? DAY_CHK : DAY_WAIT;
      DONE:     state_d = IDLE;
      default:  state_d = IDLE;
    endcase
    if ((state_q != IDLE) && abort) begin
      state_d = IDLE;
      err_d   = 1'b0;
    end else begin
      state_d = state_d;
    end
  end

  assign adv_req = {state_d == DAY_ADV, state_d == HRS_ADV, state_d == MIN_ADV};

`ifdef AUTOSET_TIMEOUT_EN
  // Per-operation pulse budget, cleared when an operation is accepted.
  always_comb begin
    steps_d = steps_q;
    if ((state_q == IDLE) && (state_d == MIN_CHK)) begin
      steps_d = 7'd0;
    end else if (adv_req != 3'b000) begin
      steps_d = steps_q + 7'd1;
    end else begin
      steps_d = steps_q;
    end
  end

  // Pulse budget register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      steps_q <= 7'd0;
    end else begin
      steps_q <= steps_d;
    end
  end
`endif

  // State, latched target and registered status outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= IDLE;
      tmin_q    <= 7'd0;
      thrs_q    <= 7'd0;
      tpm_q     <= 1'b0;
      tday_q    <= 3'd0;
      err_q     <= 1'b0;
      done_q    <= 1'b0;
      busy_q    <= 1'b0;
      timeset_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      tmin_q    <= tmin_d;
      thrs_q    <= thrs_d;
      tpm_q     <= tpm_d;
      tday_q    <= tday_d;
      err_q     <= err_d;
      done_q    <= (state_d == DONE);
      busy_q    <= (state_d != IDLE);
      timeset_q <= (state_d != IDLE);
    end
  end

  autoset_pulser #(.SETTLE(SETTLE)) u_pulser (
    .clk       (clk),
    .rst       (rst),
    .adv_req   (adv_req),
    .adv_pulse (adv_pulse),
    .settled   (settled)
  );

  assign minadv  = adv_pulse[0];
  assign hrsadv  = adv_pulse[1];
  assign dayadv  = adv_pulse[2];
  assign timeset = timeset_q;
  assign busy    = busy_q;
  assign done    = done_q;
  assign err     = err_q;

endmodule

// File: tb/tb_clock_autoset.sv
// Randomized bench for clock_autoset with a behavioural clock-core model.
module tb_clock_autoset;

  localparam int SETTLE = 2;
  localparam int GAP    = SETTLE + 2;

  logic       clk, rst, start, abort;
  logic [6:0] tgt_min, tgt_hrs;
  logic       tgt_pm;
  logic [2:0] tgt_day;
  logic [6:0] cur_min, cur_hrs;
  logic       cur_pm;
  logic [2:0] cur_day;
  logic       timeset, minadv, hrsadv, dayadv, busy, done, err;

  logic       preset_en, freeze;
  logic [6:0] p_min, p_hrs;
  logic       p_pm;
  logic [2:0] p_day;

  int n_tests, n_fail;
  int r_min, r_hrs, r_day, r_done, r_err, r_busy, r_done_n, r_viol, r_space;
  bit r_fin;

  clock_autoset #(.SETTLE(SETTLE)) dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort),
    .tgt_min(tgt_min), .tgt_hrs(tgt_hrs), .tgt_pm(tgt_pm), .tgt_day(tgt_day),
    .cur_min(cur_min), .cur_hrs(cur_hrs), .cur_pm(cur_pm), .cur_day(cur_day),
    .timeset(timeset), .minadv(minadv), .hrsadv(hrsadv), .dayadv(dayadv),
    .busy(busy), .done(done), .err(err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Clock-core model: buttons step one field; 11 PM -> 12 AM carries into the day.
  always @(posedge clk) begin
    if (preset_en) begin
      cur_min <= p_min; cur_hrs <= p_hrs; cur_pm <= p_pm; cur_day <= p_day;
    end else begin
      if (minadv && !freeze) cur_min <= (cur_min == 7'd59) ? 7'd0 : cur_min + 7'd1;
      if (hrsadv) begin
        if (cur_hrs == 7'd11) begin
          cur_hrs <= 7'd0;
          cur_pm  <= ~cur_pm;
          if (cur_pm) cur_day <= (cur_day == 3'd6) ? 3'd0 : cur_day + 3'd1;
        end else begin
          cur_hrs <= cur_hrs + 7'd1;
        end
      end
      if (dayadv) cur_day <= (cur_day == 3'd6) ? 3'd0 : cur_day + 3'd1;
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic preset(input int m, input int h, input int p, input int d);
    @(negedge clk);
    p_min = 7'(m); p_hrs = 7'(h); p_pm = 1'(p); p_day = 3'(d);
    preset_en = 1'b1;
    @(negedge clk);
    preset_en = 1'b0;
  endtask

  task automatic kick(input int m, input int h, input int p, input int d);
    @(negedge clk);
    tgt_min = 7'(m); tgt_hrs = 7'(h); tgt_pm = 1'(p); tgt_day = 3'(d);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Starts one operation and observes it until busy falls or the budget runs out.
  task automatic run_op(input int m, input int h, input int p, input int d,
                        input int budget, input bit noise);
    int last;
    r_min = 0; r_hrs = 0; r_day = 0; r_done = 0; r_err = 0; r_busy = 0;
    r_done_n = 0; r_viol = 0; r_space = 0; r_fin = 1'b0; last = -1;
    kick(m, h, p, d);
    for (int n = 1; n <= budget; n++) begin
      if (n > 1) @(negedge clk);
      if (timeset !== busy) r_viol++;
      if ((32'(minadv) + 32'(hrsadv) + 32'(dayadv)) > 32'd1) r_viol++;
      if (minadv) begin
        if ((last > 0) && (n - last != GAP)) r_space++;
        last = n;
        r_min++;
      end
      if (hrsadv) r_hrs++;
      if (dayadv) r_day++;
      if (err) r_err++;
      if (done) begin r_done++; r_done_n = n; end
      if (busy) r_busy++;
      if (!busy) begin
        start = 1'b0;
        r_fin = 1'b1;
        break;
      end
      if (noise) begin
        start   = 1'($urandom_range(1, 0));
        tgt_min = 7'($urandom_range(127, 0));
        tgt_hrs = 7'($urandom_range(127, 0));
        tgt_pm  = 1'($urandom_range(1, 0));
        tgt_day = 3'($urandom_range(7, 0));
      end
    end
    start = 1'b0;
  endtask

  // Expected results from modular distances between current and target time.
  task automatic check_good(input string tag, input int tm, input int th, input int tp,
                            input int td, input int noise);
    int cm, ch24, cd, th24, mp, hp, wrap, dp, steps;
    cm = int'(cur_min); ch24 = int'(cur_hrs) + (cur_pm ? 12 : 0); cd = int'(cur_day);
    th24 = th + (tp != 0 ? 12 : 0);
    mp = (tm - cm + 60) % 60;
    hp = (th24 - ch24 + 24) % 24;
    wrap = (ch24 + hp >= 24) ? 1 : 0;
    dp = (td - ((cd + wrap) % 7) + 7) % 7;
    steps = mp + hp + dp;
    run_op(tm, th, tp, td, 2000, noise[0]);
    chk({tag, ".fin"}, 32'(r_fin), 32'd1);
    chk({tag, ".minadv"}, r_min, mp);
    chk({tag, ".hrsadv"}, r_hrs, hp);
    chk({tag, ".dayadv"}, r_day, dp);
    chk({tag, ".done"}, r_done, 1);
    chk({tag, ".err"}, r_err, 0);
    chk({tag, ".done_at"}, r_done_n, 4 + steps * GAP);
    chk({tag, ".busy_cyc"}, r_busy, 4 + steps * GAP);
    chk({tag, ".viol"}, r_viol, 0);
    chk({tag, ".spacing"}, r_space, 0);
    chk({tag, ".final"}, {cur_min, cur_hrs, cur_pm, cur_day},
        {7'(tm), 7'(th), 1'(tp), 3'(td)});
  endtask

  task automatic check_reject(input string tag, input int m, input int h, input int d);
    run_op(m, h, 0, d, 20, 1'b0);
    chk({tag, ".err"}, r_err, 1);
    chk({tag, ".busy"}, r_busy, 0);
    chk({tag, ".adv"}, r_min + r_hrs + r_day, 0);
    chk({tag, ".done"}, r_done, 0);
  endtask

  initial begin
    bit found;
    int quiet;
    n_tests = 0; n_fail = 0;
    rst = 1'b0; start = 1'b0; abort = 1'b0; freeze = 1'b0; preset_en = 1'b0;
    tgt_min = 7'd0; tgt_hrs = 7'd0; tgt_pm = 1'b0; tgt_day = 3'd0;
    p_min = 7'd0; p_hrs = 7'd0; p_pm = 1'b0; p_day = 3'd0;
    cur_min = 7'd0; cur_hrs = 7'd0; cur_pm = 1'b0; cur_day = 3'd0;
    repeat (3) @(negedge clk);
    chk("reset_outs", {25'd0, timeset, minadv, hrsadv, dayadv, busy, done, err}, 32'd0);
    rst = 1'b1;

    preset(0, 0, 0, 0);
    check_good("full_set", 5, 3, 1, 2, 0);
    check_good("already_equal", 5, 3, 1, 2, 0);
    preset(58, 4, 0, 1);
    check_good("min_wrap", 2, 4, 0, 1, 0);
    preset(30, 11, 1, 6);
    check_good("hrs_day_wrap", 30, 1, 0, 3, 0);

    check_reject("bad_min", 60, 0, 0);
    check_reject("bad_hrs", 0, 12, 0);
    check_reject("bad_day", 0, 0, 7);

    // Abort while waiting after an hour pulse.
    preset(0, 0, 0, 0);
    kick(0, 5, 0, 0);
    found = 1'b0;
    for (int n = 0; n < 50; n++) begin
      if (hrsadv) begin found = 1'b1; break; end
      @(negedge clk);
    end
    chk("abort.reach", 32'(found), 32'd1);
    @(negedge clk);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    chk("abort.busy", 32'(busy), 32'd0);
    chk("abort.timeset", 32'(timeset), 32'd0);
    chk("abort.done", 32'(done), 32'd0);
    quiet = 0;
    for (int n = 0; n < 10; n++) begin
      @(negedge clk);
      quiet += int'(done) + int'(err) + int'(busy);
    end
    chk("abort.quiet", quiet, 0);

    // Reset during a day pulse.
    preset(0, 0, 0, 0);
    kick(0, 0, 0, 3);
    found = 1'b0;
    for (int n = 0; n < 50; n++) begin
      if (dayadv) begin found = 1'b1; break; end
      @(negedge clk);
    end
    chk("rst.reach", 32'(found), 32'd1);
    rst = 1'b0;
    #1;
    chk("rst.dayadv", 32'(dayadv), 32'd0);
    chk("rst.busy", 32'(busy), 32'd0);
    chk("rst.timeset", 32'(timeset), 32'd0);
    @(negedge clk);
    rst = 1'b1;
    quiet = 0;
    for (int n = 0; n < 20; n++) begin
      @(negedge clk);
      quiet += int'(done) + int'(err) + int'(busy) + int'(dayadv);
    end
    chk("rst.quiet", quiet, 0);

    // Frozen minute counter: never matches.
    preset(0, 0, 0, 0);
    freeze = 1'b1;
`ifdef AUTOSET_TIMEOUT_EN
    run_op(1, 0, 0, 0, 2000, 1'b0);
    chk("frozen.fin", 32'(r_fin), 32'd1);
    chk("frozen.minadv", r_min, 91);
    chk("frozen.err", r_err, 1);
    chk("frozen.done", r_done, 0);
`else
    run_op(1, 0, 0, 0, 200, 1'b0);
    chk("frozen.fin", 32'(r_fin), 32'd0);
    chk("frozen.busy", 32'(busy), 32'd1);
    chk("frozen.err", r_err, 0);
    @(negedge clk);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    chk("frozen.abort", 32'(busy), 32'd0);
`endif
    freeze = 1'b0;

    for (int i = 0; i < 20; i++) begin
      check_good("rand", $urandom_range(59, 0), $urandom_range(11, 0),
                 $urandom_range(1, 0), $urandom_range(6, 0), 1);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/clock_autoset.md
CLOCK_AUTOSET -- requirements
Module: clock_autoset

Interface
REQ-001 SHALL have parameter: SETTLE, 1, idle cycles after each advance pulse before re-comparing (1..7).
REQ-002 SHALL have port: clk  input  1  single clock, all state on rising edge.
REQ-003 SHALL have port: rst  input  1  asynchronous, active-low reset.
REQ-004 SHALL have port: start  input  1  request to set clock to target, sampled only in IDLE.
REQ-005 SHALL have port: abort  input  1  cancel an in-progress operation.
REQ-006 SHALL have ports: tgt_min  input  7  (0..59); tgt_hrs  input  7  (0..11, 0 means 12); tgt_pm  input  1; tgt_day  input  3  (0..6).
REQ-007 SHALL have ports: cur_min  input  7; cur_hrs  input  7; cur_pm  input  1; cur_day  input  3; live time from the clock core, same encodings.
REQ-008 SHALL have ports: timeset, minadv, hrsadv, dayadv  output  1 each  button drive into the clock core.
REQ-009 SHALL have ports: busy  output  1; done  output  1  one-cycle pulse on success; err  output  1  one-cycle pulse on rejection or timeout.

Function
REQ-010 SHALL implement states IDLE, MIN_CHK, MIN_ADV, MIN_WAIT, HRS_CHK, HRS_ADV, HRS_WAIT, DAY_CHK, DAY_ADV, DAY_WAIT, DONE.
REQ-011 SHALL latch all tgt_* on the edge where start=1 in IDLE and SHALL move to MIN_CHK on that edge.
REQ-012 SHALL pulse err for one cycle and stay in IDLE, with no advance output, if latched tgt_min>59, tgt_hrs>11 or tgt_day>6.
REQ-013 SHALL, in X_CHK, go to X_ADV if the phase field differs from target, else go to the next phase's CHK (MIN->HRS->DAY->DONE).
REQ-014 SHALL treat the HRS phase as matched only when cur_hrs==tgt_hrs and cur_pm==tgt_pm.
REQ-015 SHALL assert exactly one of minadv/hrsadv/dayadv for exactly the one cycle spent in the matching X_ADV state.
REQ-016 SHALL hold X_WAIT for SETTLE cycles, then return to X_CHK.
REQ-017 SHALL drive timeset=1 in every state except IDLE, so the seconds counter stays frozen for the whole operation.
REQ-018 SHALL set the day last, because hour wrap past 11 PM advances the day in the clock core.
REQ-019 SHALL drive busy=1 in every state except IDLE.
REQ-020 SHALL drive done=1 only during the single DONE cycle, then go to IDLE.
REQ-021 SHALL ignore start while busy.
REQ-022 SHALL, on abort=1 in any non-IDLE state, go to IDLE on the next edge with no done and no err; abort has priority over all other transitions.
REQ-023 SHALL treat minute wrap (59->0) and hour wrap (11->0 with pm toggle) as plain repeated advances, with no special path.

Reset
REQ-024 SHALL, while rst=0, immediately force state=IDLE and all outputs (timeset, minadv, hrsadv, dayadv, busy, done, err) to 0, with latched targets cleared to 0.
REQ-025 SHALL, on reset asserted mid-operation, discard that operation with no done or err afterwards.

Configuration
REQ-026 SHALL, with AUTOSET_TIMEOUT_EN defined, count advance pulses per operation and, when a 92nd pulse would be issued (limit 60+24+7=91), pulse err and go to IDLE instead.
REQ-027 SHALL, without AUTOSET_TIMEOUT_EN, include no pulse counter and remain busy until match or abort.

Structure
REQ-028 SHALL take the following from shared package clock_pkg: state enum, MIN_MAX=59, HRS_MAX=11, DAY_MAX=6, MAX_STEPS=91.
REQ-029 SHALL place the one-cycle pulse plus SETTLE wait timer in sub-module autoset_pulser; phase sequencing stays in clock_autoset.

Verification (bench includes behavioural clock-core model)
REQ-030 SHALL cover: cur 12:00 AM day0, target min5 hrs3 PM day2 -> 5 minadv, 15 hrsadv, 2 dayadv pulses, one done, final cur equals target.
REQ-031 SHALL cover: target equals current, start at edge k -> zero advance pulses, done high in cycle k+4, busy high cycles k+1..k+4.
REQ-032 SHALL cover: cur_min 58, target 2, other fields equal -> exactly 4 minadv pulses each spaced SETTLE+2 cycles, then done.
REQ-033 SHALL cover: tgt_min=60 -> err one cycle, busy never rises, all advance outputs stay 0.
REQ-034 SHALL cover: abort during HRS_WAIT -> next cycle busy=0 and timeset=0, no done; rst=0 mid-DAY_ADV -> dayadv drops immediately.
REQ-035 SHALL cover: frozen clock-core model that never updates cur_min -> with AUTOSET_TIMEOUT_EN, err after 91 minadv pulses; without it, busy stays 1 after 200 cycles.
